csi_ph_ecc_decoder: RTL and testbench

- Registered MIPI CSI-2 packet-header ECC checker/corrector in the CSI receiver, placed after lane merging and before the packet decoder.
- Takes one 32-bit header: data in [23:0], ECC in [31:24].
- Recomputes the 6-bit Hamming parity and forms a syndrome.
- Outputs the 24-bit header with any single-bit error corrected, plus no/corrected/uncorrectable status and error counters.

---
 rtl/csi_pkg.sv | 31 +++
 rtl/csi_ecc_syndrome.sv | 31 +++
 rtl/csi_ph_ecc_decoder.sv | 105 ++++++++++
 tb/tb_csi_ph_ecc_decoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared CSI-2 packet-header constants, syndrome type and Hamming parity function.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csi_pkg;

    localparam int PH_SIZE   = 32;
    localparam int ECC_SIZE  = 8;
    localparam int DATA_SIZE = PH_SIZE - ECC_SIZE;

    typedef logic [5:0] syndrome_t;

    // Syndrome produced by a single flipped data bit D[k]; each entry is also the
    // set of parity bits that D[k] feeds, so it doubles as the generator matrix.
    localparam syndrome_t COL_SYN [DATA_SIZE] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    function automatic syndrome_t calc_parity(input logic [DATA_SIZE-1:0] d);
        syndrome_t p;
        p = '0;
        for (int k = 0; k < DATA_SIZE; k++) begin
            if (d[k]) begin
                p = p ^ COL_SYN[k];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/csi_ecc_syndrome.sv
// Combinational parity recompute, syndrome and single-bit correction mask.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module csi_ecc_syndrome
    import csi_pkg::*;
(
    input  logic [DATA_SIZE-1:0] data,
    input  syndrome_t            ecc_rx,
    output syndrome_t            syndrome,
    output logic [DATA_SIZE-1:0] corr_mask,
    output logic                 syn_zero,
    output logic                 data_hit,
    output logic                 ecc_hit
);

    assign syndrome = ecc_rx ^ calc_parity(data);
    assign syn_zero = (syndrome == '0);
    assign ecc_hit  = $onehot(syndrome);

    always_comb begin
        corr_mask = '0;
        data_hit  = 1'b0;
        for (int k = 0; k < DATA_SIZE; k++) begin
            if (syndrome == COL_SYN[k]) begin
                corr_mask[k] = 1'b1;
                data_hit     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csi_ph_ecc_decoder.sv
// CSI-2 packet-header ECC checker/corrector with saturating error counters; CSI_ECC_RSVD_CHECK_EN flags nonzero reserved bits.
// Latency: 1 cycle, one header per cycle.
// Backpressure: none; a header presented with ph_valid is always consumed.
module csi_ph_ecc_decoder
    import csi_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ph_valid,
    input  logic [PH_SIZE-1:0]   ph_in,
    input  logic                 cnt_clr,
    output logic [DATA_SIZE-1:0] ph_out,
    output logic                 ph_out_valid,
    output logic                 no_error,
    output logic                 corrected_error,
    output logic                 error,
    output syndrome_t            syndrome,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);

    syndrome_t            syn_c;
    logic [DATA_SIZE-1:0] corr_mask;
    logic                 syn_zero;
    logic                 data_hit;
    logic                 ecc_hit;
    logic                 rsvd_bad;

    logic [DATA_SIZE-1:0] data_d;
    logic                 no_err_d;
    logic                 corr_d;
    logic                 err_d;

    csi_ecc_syndrome u_syn (
        .data      (ph_in[DATA_SIZE-1:0]),
        .ecc_rx    (ph_in[DATA_SIZE+5:DATA_SIZE]),
        .syndrome  (syn_c),
        .corr_mask (corr_mask),
        .syn_zero  (syn_zero),
        .data_hit  (data_hit),
        .ecc_hit   (ecc_hit)
    );

`ifdef CSI_ECC_RSVD_CHECK_EN
    assign rsvd_bad = |ph_in[PH_SIZE-1:PH_SIZE-2];
`else
    logic unused_rsvd;
    assign unused_rsvd = ^ph_in[PH_SIZE-1:PH_SIZE-2];
    assign rsvd_bad    = 1'b0;
`endif

    always_comb begin
        no_err_d = syn_zero;
        corr_d   = data_hit | ecc_hit;
        err_d    = ~(syn_zero | data_hit | ecc_hit);
        data_d   = ph_in[DATA_SIZE-1:0] ^ corr_mask;
        if (rsvd_bad) begin
            no_err_d = 1'b0;
            corr_d   = 1'b0;
            err_d    = 1'b1;
            data_d   = ph_in[DATA_SIZE-1:0];
        end
    end

    // Data and syndrome hold across idle cycles; status flags are per-header pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_out          <= '0;
            syndrome        <= '0;
            ph_out_valid    <= 1'b0;
            no_error        <= 1'b0;
            corrected_error <= 1'b0;
            error           <= 1'b0;
        end else begin
            ph_out_valid    <= ph_valid;
            no_error        <= ph_valid & no_err_d;
            corrected_error <= ph_valid & corr_d;
            error           <= ph_valid & err_d;
            if (ph_valid) begin
                ph_out   <= data_d;
                syndrome <= syn_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (ph_valid && corr_d && (corr_cnt != {CNT_W{1'b1}})) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (ph_valid && err_d && (uncorr_cnt != {CNT_W{1'b1}})) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_csi_ph_ecc_decoder.sv
// Directed-vector bench for csi_ph_ecc_decoder; counters narrowed to 4 bits so saturation is reachable.
module tb_csi_ph_ecc_decoder;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          ph_valid;
    logic [31:0]   ph_in;
    logic          cnt_clr;
    logic [23:0]   ph_out;
    logic          ph_out_valid;
    logic          no_error;
    logic          corrected_error;
    logic          error;
    logic [5:0]    syndrome;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    int checks;
    int failures;
    int exp_corr;
    int exp_uncorr;

    csi_ph_ecc_decoder #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ph_valid        (ph_valid),
        .ph_in           (ph_in),
        .cnt_clr         (cnt_clr),
        .ph_out          (ph_out),
        .ph_out_valid    (ph_out_valid),
        .no_error        (no_error),
        .corrected_error (corrected_error),
        .error           (error),
        .syndrome        (syndrome),
        .corr_cnt        (corr_cnt),
        .uncorr_cnt      (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, return 1 time unit after the next rising edge.
    task automatic step(input logic v, input logic [31:0] h, input logic c);
        @(negedge clk);
        ph_valid = v;
        ph_in    = h;
        cnt_clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ph_valid = 1'b0;
        ph_in    = '0;
        cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ph_out, ph_out_valid, no_error, corrected_error, error, syndrome, corr_cnt, uncorr_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ph_out=%h vld=%b flags=%b%b%b syn=%h cc=%0d uc=%0d, expected all zero",
                     ph_out, ph_out_valid, no_error, corrected_error, error, syndrome, corr_cnt, uncorr_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean();
        step(1'b1, 32'h09000110, 1'b0);
        checks++;
        if ({ph_out_valid, ph_out, no_error, corrected_error, error, syndrome} !== {1'b1, 24'h000110, 3'b100, 6'h00}) begin
            failures++;
            $display("FAIL clean_hdr: vld=%b ph_out=%h flags=%b%b%b syn=%h, expected 1 000110 100 00",
                     ph_out_valid, ph_out, no_error, corrected_error, error, syndrome);
        end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== {4'd0, 4'd0}) begin
            failures++;
            $display("FAIL clean_cnt: cc=%0d uc=%0d, expected 0 0", corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_data_flips();
        int          bits [12] = '{0, 1, 2, 3, 16, 17, 18, 19, 20, 21, 22, 23};
        logic [5:0]  syns [12] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h31, 6'h32,
                                   6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
        logic [31:0] h;
        for (int i = 0; i < 12; i++) begin
            h = 32'h09000110 ^ (32'h1 << bits[i]);
            step(1'b1, h, 1'b0);
            exp_corr++;
            checks++;
            if ({ph_out_valid, ph_out, no_error, corrected_error, error, syndrome} !== {1'b1, 24'h000110, 3'b010, syns[i]}) begin
                failures++;
                $display("FAIL data_flip_bit%0d: vld=%b ph_out=%h flags=%b%b%b syn=%h, expected 1 000110 010 %h",
                         bits[i], ph_out_valid, ph_out, no_error, corrected_error, error, syndrome, syns[i]);
            end
            checks++;
            if (corr_cnt !== CW'(exp_corr)) begin
                failures++;
                $display("FAIL data_flip_cnt%0d: cc=%0d, expected %0d", bits[i], corr_cnt, exp_corr);
            end
        end
    endtask

    task automatic test_ecc_flip();
        step(1'b1, 32'h08000110, 1'b0);
        exp_corr++;
        checks++;
        if ({ph_out, no_error, corrected_error, error, syndrome, corr_cnt} !== {24'h000110, 3'b010, 6'h01, CW'(exp_corr)}) begin
            failures++;
            $display("FAIL ecc_flip: ph_out=%h flags=%b%b%b syn=%h cc=%0d, expected 000110 010 01 %0d",
                     ph_out, no_error, corrected_error, error, syndrome, corr_cnt, exp_corr);
        end
    endtask

    task automatic test_double();
        step(1'b1, 32'h09010111, 1'b0);
        exp_uncorr++;
        checks++;
        if ({ph_out, no_error, corrected_error, error, syndrome} !== {24'h010111, 3'b001, 6'h36}) begin
            failures++;
            $display("FAIL double_0_16: ph_out=%h flags=%b%b%b syn=%h, expected 010111 001 36",
                     ph_out, no_error, corrected_error, error, syndrome);
        end
        step(1'b1, 32'h09200112, 1'b0);
        exp_uncorr++;
        checks++;
        if ({ph_out, no_error, corrected_error, error, syndrome} !== {24'h200112, 3'b001, 6'h24}) begin
            failures++;
            $display("FAIL double_1_21: ph_out=%h flags=%b%b%b syn=%h, expected 200112 001 24",
                     ph_out, no_error, corrected_error, error, syndrome);
        end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== {CW'(exp_corr), CW'(exp_uncorr)}) begin
            failures++;
            $display("FAIL double_cnt: cc=%0d uc=%0d, expected %0d %0d", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'h09000110, 1'b0);
        checks++;
        if ({ph_out_valid, ph_out, no_error, corrected_error, error} !== {1'b1, 24'h000110, 3'b100}) begin
            failures++;
            $display("FAIL b2b_0: vld=%b ph_out=%h flags=%b%b%b, expected 1 000110 100",
                     ph_out_valid, ph_out, no_error, corrected_error, error);
        end
        step(1'b1, 32'h09000111, 1'b0);
        exp_corr++;
        checks++;
        if ({ph_out_valid, ph_out, no_error, corrected_error, error, syndrome} !== {1'b1, 24'h000110, 3'b010, 6'h07}) begin
            failures++;
            $display("FAIL b2b_1: vld=%b ph_out=%h flags=%b%b%b syn=%h, expected 1 000110 010 07",
                     ph_out_valid, ph_out, no_error, corrected_error, error, syndrome);
        end
        step(1'b1, 32'h09010111, 1'b0);
        exp_uncorr++;
        checks++;
        if ({ph_out_valid, ph_out, no_error, corrected_error, error, syndrome} !== {1'b1, 24'h010111, 3'b001, 6'h36}) begin
            failures++;
            $display("FAIL b2b_2: vld=%b ph_out=%h flags=%b%b%b syn=%h, expected 1 010111 001 36",
                     ph_out_valid, ph_out, no_error, corrected_error, error, syndrome);
        end
        step(1'b0, 32'h09000111, 1'b0);
        checks++;
        if ({ph_out_valid, no_error, corrected_error, error, ph_out, syndrome} !== {4'b0000, 24'h010111, 6'h36}) begin
            failures++;
            $display("FAIL b2b_idle: vld=%b flags=%b%b%b ph_out=%h syn=%h, expected 0 000 010111 36",
                     ph_out_valid, no_error, corrected_error, error, ph_out, syndrome);
        end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== {CW'(exp_corr), CW'(exp_uncorr)}) begin
            failures++;
            $display("FAIL b2b_cnt: cc=%0d uc=%0d, expected %0d %0d", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h08000110, 1'b0);
            if (exp_corr < 15) exp_corr++;
            checks++;
            if (corr_cnt !== CW'(exp_corr)) begin
                failures++;
                $display("FAIL sat_step%0d: cc=%0d, expected %0d", i, corr_cnt, exp_corr);
            end
        end
        checks++;
        if (corr_cnt !== 4'hF) begin
            failures++;
            $display("FAIL sat_hold: cc=%0d, expected 15", corr_cnt);
        end
    endtask

    task automatic test_clr_priority();
        step(1'b1, 32'h09010111, 1'b1);
        exp_corr   = 0;
        exp_uncorr = 0;
        checks++;
        if ({corr_cnt, uncorr_cnt, error} !== {4'd0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL clr_priority: cc=%0d uc=%0d err=%b, expected 0 0 1", corr_cnt, uncorr_cnt, error);
        end
    endtask

    task automatic test_rsvd();
        step(1'b1, 32'h49000110, 1'b0);
`ifdef CSI_ECC_RSVD_CHECK_EN
        exp_uncorr++;
        checks++;
        if ({ph_out, no_error, corrected_error, error, uncorr_cnt} !== {24'h000110, 3'b001, CW'(exp_uncorr)}) begin
            failures++;
            $display("FAIL rsvd_bits: ph_out=%h flags=%b%b%b uc=%0d, expected 000110 001 %0d",
                     ph_out, no_error, corrected_error, error, uncorr_cnt, exp_uncorr);
        end
`else
        checks++;
        if ({ph_out, no_error, corrected_error, error, uncorr_cnt} !== {24'h000110, 3'b100, CW'(exp_uncorr)}) begin
            failures++;
            $display("FAIL rsvd_bits: ph_out=%h flags=%b%b%b uc=%0d, expected 000110 100 %0d",
                     ph_out, no_error, corrected_error, error, uncorr_cnt, exp_uncorr);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 32'h09000111, 1'b0);
        exp_corr++;
        checks++;
        if ({ph_out_valid, corrected_error, corr_cnt} !== {2'b11, CW'(exp_corr)}) begin
            failures++;
            $display("FAIL midrst_pre: vld=%b corr=%b cc=%0d, expected 1 1 %0d",
                     ph_out_valid, corrected_error, corr_cnt, exp_corr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ph_out, ph_out_valid, no_error, corrected_error, error, syndrome, corr_cnt, uncorr_cnt} !== '0) begin
            failures++;
            $display("FAIL midrst_async: ph_out=%h vld=%b flags=%b%b%b syn=%h cc=%0d uc=%0d, expected all zero",
                     ph_out, ph_out_valid, no_error, corrected_error, error, syndrome, corr_cnt, uncorr_cnt);
        end
        @(negedge clk);
        ph_valid = 1'b0;
        rst_n    = 1'b1;
        exp_corr   = 0;
        exp_uncorr = 0;
        step(1'b1, 32'h09800110, 1'b0);
        exp_corr++;
        checks++;
        if ({ph_out_valid, ph_out, no_error, corrected_error, error, syndrome, corr_cnt} !==
            {1'b1, 24'h000110, 3'b010, 6'h3B, CW'(exp_corr)}) begin
            failures++;
            $display("FAIL midrst_post: vld=%b ph_out=%h flags=%b%b%b syn=%h cc=%0d, expected 1 000110 010 3b %0d",
                     ph_out_valid, ph_out, no_error, corrected_error, error, syndrome, corr_cnt, exp_corr);
        end
        step(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_corr   = 0;
        exp_uncorr = 0;
        test_reset();
        test_clean();
        test_data_flips();
        test_ecc_flip();
        test_double();
        test_back_to_back();
        test_saturation();
        test_clr_priority();
        test_rsvd();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
